// File: rtl/message_pkg.sv
// Shared framing definitions for the 5-bit message link (transmitter and receiver).
package message_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } state_e;

  localparam int unsigned MSG_W_DEF      = 5;
  localparam int unsigned BIT_CYCLES_DEF = 16;
  localparam logic        LINE_IDLE      = 1'b1;

endpackage

// File: rtl/message_receive_bit_timer.sv
// Bit-period timer: first tick after a half period (half=1), then every full period.
module bit_timer #(
  parameter int unsigned BIT_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic half,
  output logic tick
);

  localparam int unsigned     CW        = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [CW-1:0]   HALF_LAST = CW'(BIT_CYCLES / 2 - 1);
  localparam logic [CW-1:0]   FULL_LAST = CW'(BIT_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Counter wraps to 0 on every tick so the next sample lands one full period later.
  always_comb begin
    tick  = !clear && (cnt_q == (half ? HALF_LAST : FULL_LAST));
    cnt_d = (clear || tick) ? '0 : cnt_q + CW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/message_receive.sv
// Serial receiver for the message link: mid-bit sampling, MSB-first reassembly, stop-bit check.
module message_receive
  import message_pkg::*;
#(
  parameter int unsigned BIT_CYCLES = BIT_CYCLES_DEF,
  parameter int unsigned MSG_W      = MSG_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             SerIn,
  output logic [MSG_W-1:0] MSG,
  output logic             valid,
  output logic             frame_err,
  output logic             busy
);

  localparam int unsigned BW = $clog2(MSG_W + 1);

  state_e           state_q;
  logic [MSG_W-1:0] sr_q;
  logic [MSG_W-1:0] msg_q;
  logic [BW-1:0]    nbits_q;
  logic             valid_q;
  logic             ferr_q;
  logic             busy_q;

  logic tick;
  logic clear;
  logic half;

  // Timer is held cleared whenever no bit timing is in progress.
  assign clear = (state_q == IDLE) || (state_q == BREAK);
  assign half  = (state_q == START);

  bit_timer #(
    .BIT_CYCLES(BIT_CYCLES)
  ) u_bit_timer (
    .clk  (clk),
    .reset(reset),
    .clear(clear),
    .half (half),
    .tick (tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      sr_q    <= '0;
      msg_q   <= '0;
      nbits_q <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (SerIn != LINE_IDLE) begin
            state_q <= START;
            busy_q  <= 1'b1;
          end
        end
        START: begin
          if (tick) begin
            if (SerIn != LINE_IDLE) begin
              state_q <= DATA;
              nbits_q <= '0;
            end else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end
        end
        DATA: begin
          if (tick) begin
            sr_q    <= (sr_q << 1) | MSG_W'(SerIn);
            nbits_q <= nbits_q + BW'(1);
            if (nbits_q == BW'(MSG_W - 1)) state_q <= STOP;
          end
        end
        STOP: begin
          if (tick) begin
            if (SerIn == LINE_IDLE) begin
              msg_q   <= sr_q;
              valid_q <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end else begin
              ferr_q  <= 1'b1;
              state_q <= BREAK;
            end
          end
        end
        BREAK: begin
          if (SerIn == LINE_IDLE) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign MSG       = msg_q;
  assign valid     = valid_q;
  assign frame_err = ferr_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_message_receive.sv
// Randomized scoreboard bench for message_receive (BIT_CYCLES=16, MSG_W=5).
module tb_message_receive;

  localparam int B        = 16;
  localparam int W        = 5;
  localparam int H        = B / 2;
  localparam int STOP_OFS = H + (W + 1) * B;

  logic       clk = 1'b0;
  logic       reset;
  logic       SerIn;
  logic [4:0] MSG;
  logic       valid;
  logic       frame_err;
  logic       busy;

  message_receive #(
    .BIT_CYCLES(B),
    .MSG_W     (W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .SerIn    (SerIn),
    .MSG      (MSG),
    .valid    (valid),
    .frame_err(frame_err),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit         is_err;
    logic [4:0] msg;
    int         at;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  logic [4:0] mon_msg = '0;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: pops one expected event per pulse and checks timing, kind and MSG.
  always @(negedge clk) begin
    if (reset) begin
      mon_msg = '0;
    end else if (valid || frame_err) begin
      check("pulse_exclusive", {31'd0, valid && frame_err}, 32'd0);
      if (sbq.size() == 0) begin
        check("unexpected_pulse", {30'd0, valid, frame_err}, 32'd0);
      end else begin
        mon_e = sbq.pop_front();
        check("pulse_kind", {31'd0, frame_err}, {31'd0, mon_e.is_err});
        check("pulse_cycle", cyc, mon_e.at);
        if (!mon_e.is_err) mon_msg = mon_e.msg;
        check("msg_on_pulse", {27'd0, MSG}, {27'd0, mon_msg});
      end
    end else begin
      check("msg_hold", {27'd0, MSG}, {27'd0, mon_msg});
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      SerIn = 1'b1;
    end
  endtask

  task automatic drive_bit(input logic v, input bit noise);
    for (int k = 0; k < B; k++) begin
      @(negedge clk);
      SerIn = (noise && k >= 1 && k <= 3) ? ~v : v;
    end
  endtask

  task automatic send_frame(input logic [4:0] m, input bit stop_ok, input int hold_low,
                            input bit noise);
    int t0;
    @(negedge clk);
    SerIn = 1'b0;
    t0 = cyc + 1;
    sbq.push_back('{is_err: !stop_ok, msg: m, at: t0 + STOP_OFS});
    @(negedge clk);
    check("busy_after_start", {31'd0, busy}, 32'd1);
    repeat (B - 2) @(negedge clk);
    for (int i = W - 1; i >= 0; i--) drive_bit(m[i], noise);
    if (stop_ok) begin
      drive_bit(1'b1, 1'b0);
    end else begin
      repeat (B + hold_low) begin
        @(negedge clk);
        SerIn = 1'b0;
      end
      check("busy_in_break", {31'd0, busy}, 32'd1);
      @(negedge clk);
      SerIn = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("busy_after_break", {31'd0, busy}, 32'd0);
    end
  endtask

  task automatic glitch(input int len);
    int t0;
    @(negedge clk);
    SerIn = 1'b0;
    t0 = cyc + 1;
    repeat (len - 1) @(negedge clk);
    @(negedge clk);
    SerIn = 1'b1;
    while (cyc < t0 + H - 1) @(negedge clk);
    check("glitch_busy_before", {31'd0, busy}, 32'd1);
    @(negedge clk);
    check("glitch_busy_fall", {31'd0, busy}, 32'd0);
  endtask

  task automatic reset_mid_frame();
    @(negedge clk);
    SerIn = 1'b0;
    repeat (49) @(negedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
    SerIn = 1'b1;
    #1;
    check("reset_mid_busy", {31'd0, busy}, 32'd0);
    check("reset_mid_outputs", {25'd0, MSG, valid, frame_err}, 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int w;
    int r;
    reset = 1'b1;
    SerIn = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_values", {24'd0, MSG, valid, frame_err, busy}, 32'd0);
    reset = 1'b0;
    idle(5);
    check("idle_busy", {31'd0, busy}, 32'd0);

    send_frame(5'b11011, 1'b1, 0, 1'b0);
    idle(3);
    glitch(3);
    idle(4);
    send_frame(5'b10101, 1'b0, 40, 1'b0);
    idle(2);
    send_frame(5'b00110, 1'b1, 0, 1'b0);
    idle(3);
    send_frame(5'b10101, 1'b1, 0, 1'b0);
    send_frame(5'b01010, 1'b1, 0, 1'b0);
    idle(3);
    reset_mid_frame();
    idle(5);
    send_frame(5'b11111, 1'b1, 0, 1'b0);
    idle(3);
    glitch(H);
    idle(2);

    for (int n = 0; n < 24; n++) begin
      r = $urandom_range(0, 9);
      if (r < 2) glitch($urandom_range(1, H));
      else send_frame(5'($urandom), r != 2, $urandom_range(0, 30), $urandom_range(0, 1) == 1);
      idle($urandom_range(0, 6));
    end

    w = 0;
    while (sbq.size() != 0 && w < 400) begin
      @(negedge clk);
      w++;
    end
    check("scoreboard_drained", sbq.size(), 32'd0);
    idle(20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/message_receive.md
# message_receive

Serial receiver for the 5-bit message link: the far end of the message serializer. It watches the single-bit line `SerIn`, detects a start bit, samples each bit at its midpoint using a cycle counter, and reassembles the 5-bit message. A complete frame is presented on `MSG` with a one-cycle `valid` strobe. A bad stop bit is reported on `frame_err`. It sits in the demodulation path after the line decision logic and shares the transmitter's clock domain.

## Interface
- `BIT_CYCLES`, 16: clock cycles per serial bit; legal values are >= 4.
- `MSG_W`, 5: message width in bits.
- `clk` in 1: single system clock, rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `SerIn` in 1: serial line, synchronous to `clk`; idles high.
- `MSG` out `MSG_W`: last correctly received message; holds its value between frames.
- `valid` out 1: one-cycle pulse when `MSG` is updated.
- `frame_err` out 1: one-cycle pulse on a bad stop bit.
- `busy` out 1: high from start detection until the frame ends or is aborted.

## Operation
- Frame format on the line:
  - idle high;
  - 1 start bit (low);
  - `MSG_W` data bits, MSB first;
  - 1 stop bit (high).
  - Every bit lasts `BIT_CYCLES` clocks.
- States:
  - IDLE: wait for `SerIn`=0, then go to START, clear the counter, set `busy`.
  - START: at the mid-start sample, if `SerIn`=0 go to DATA; if `SerIn`=1 the start is false, so go to IDLE and clear `busy`, with no pulses.
  - DATA: shift in one bit per bit period. After `MSG_W` samples, go to STOP.
  - STOP: sample the stop bit.
    - `SerIn`=1: load the shift register into `MSG`, pulse `valid`, go to IDLE.
    - `SerIn`=0: pulse `frame_err`, leave `MSG` unchanged, go to BREAK.
  - BREAK: wait for `SerIn`=1, then go to IDLE. `busy` stays high while in BREAK.
- Counter width is clog2(`BIT_CYCLES`). It wraps to 0 at each sample point. It is not free-running in IDLE.
- `valid` and `frame_err` are never high in the same cycle.

## Timing
- Reset values: `MSG`=0, `valid`=0, `frame_err`=0, `busy`=0, state IDLE, counter 0, shift register 0.
- Reset asserted mid-frame aborts the frame immediately. No pulse is emitted and `MSG` clears to 0.
- Let t0 be the first edge in IDLE with `SerIn`=0, and H = floor(`BIT_CYCLES`/2).
- `busy` is registered high after t0.
- Start sample: edge t0+H.
- Data bit i (i = 0..`MSG_W`-1, MSB first) is sampled at edge t0+H+(i+1)·`BIT_CYCLES`.
- Stop sample: edge t0+H+(`MSG_W`+1)·`BIT_CYCLES`.
  - `MSG`, `valid` and `frame_err` update at this edge.
  - `busy` falls at the same edge on a good frame.
- The earliest next start detection is the edge after the stop sample, so back-to-back frames (the next start immediately after the stop bit) are received without loss.
- Line changes between sample points are ignored. Only the mid-bit sample matters.

## Structure
- Package `message_pkg` holds:
  - the state enum (IDLE, START, DATA, STOP, BREAK);
  - the default `MSG_W`=5 and `BIT_CYCLES`=16;
  - the idle-level constant (1).
- The transmitter imports the same package, so framing stays consistent in both directions.
- One sub-module, `bit_timer`:
  - inputs: `clk`, `reset`, `clear`, `half`;
  - output: one-cycle `tick` at the half-period (first tick) and then at each full period;
  - parameter: `BIT_CYCLES`.
- Shift register and FSM stay in `message_receive`.

## Test plan
All scenarios use `BIT_CYCLES`=16, so H=8.
- Good frame: drive frame 11011 starting at t0. Required: `MSG`=5'b11011 and a 1-cycle `valid` at t0+104; `busy` high over (t0, t0+104].
- Glitch: drive `SerIn` low for 3 cycles, then high. Required: `busy` falls at t0+8; no `valid` or `frame_err`; `MSG` unchanged.
- Bad stop: send 10101 with a low stop bit and hold the line low 40 more cycles. Required:
  - `frame_err` pulses at t0+104 and `MSG` keeps its previous value;
  - `busy` stays high until the line returns high;
  - a following good 00110 frame is then received.
- Back-to-back: send 10101 then 01010 with no idle gap. Required: two `valid` pulses 112 cycles apart, with `MSG`=10101 then `MSG`=01010.
- Reset mid-frame: assert `reset` at t0+50. Required: all outputs are 0 immediately; no pulse follows; the next full frame 11111 is received correctly.
- Loopback: connect `SerOut` of the transmitter to `SerIn`, load 11011 with `send`=1. Required: exactly one `valid` with `MSG`=11011.
